// File: rtl/fsm_pkg.sv
// Shared definitions for the serial pattern detector.
// State encoding and its width, used by the detector top.
package fsm_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10,
    ST_HIT   = 2'b11
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset_n (async low), clr, inc, q (count).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  // clr wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/fsm_seq_detect_param.sv
// Serial pattern detector: Mealy strobe, Moore strobe, hit counter.
// Ports: clk, reset_n, en, clr, din_valid, din, pattern, overlap,
//        mealy_hit, moore_hit, hit_count, state_dbg.
module fsm_seq_detect_param
  import fsm_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               clr,
  input  logic               din_valid,
  input  logic               din,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               mealy_hit,
  output logic               moore_hit,
  output logic [CNT_W-1:0]   hit_count,
  output logic [ST_W-1:0]    state_dbg
);

  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);
  localparam logic [FW-1:0] FILL_ONE = FW'(1);

  state_t state_q;
  state_t state_d;

  // Only the older PAT_LEN-1 bits are stored;
  // the newest bit is din itself.
  logic [PAT_LEN-2:0] win_q;
  logic [PAT_LEN-2:0] win_d;
  logic [PAT_LEN-1:0] win_sh;

  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;

  logic accept;
  logic full;

  assign accept = en & din_valid & ~clr;
  assign win_sh = {win_q, din};
  assign full   = (fill_q == FILL_MAX);

  assign mealy_hit = accept & full &
                     (win_sh == pattern);

  // Window / fill datapath
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clr) begin
      win_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      win_d = win_sh[PAT_LEN-2:0];
      if (mealy_hit) begin
        // overlap keeps the window armed;
        // otherwise a full new pattern is needed
        fill_d = overlap ? FILL_MAX : '0;
      end else if (!full) begin
        fill_d = fill_q + FILL_ONE;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_FILL;
    if (clr) begin
      state_d = en ? ST_FILL : ST_IDLE;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else if (mealy_hit) begin
      state_d = ST_HIT;
    end else if (fill_d == FILL_MAX) begin
      state_d = ST_ARMED;
    end else begin
      state_d = ST_FILL;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
    end
  end

  // Output logic
  assign moore_hit = (state_q == ST_HIT);
  assign state_dbg = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .inc    (mealy_hit),
    .q      (hit_count)
  );

endmodule

// File: tb/tb_fsm_seq_detect_param.sv
// Bench for fsm_seq_detect_param: two counter widths,
// directed scenarios plus randomized stream vs. a model.
module tb_fsm_seq_detect_param;

  localparam int P = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic overlap = 1'b0;
  logic [P-1:0] pattern = '0;

  logic mh_a, mo_a, mh_b, mo_b;
  logic [7:0] hc_a;
  logic [1:0] hc_b;
  logic [1:0] sd_a, sd_b;

  int total = 0;
  int bad = 0;

  // model: accepted-bit history, bits since restart,
  // unbounded hit total, expected state code
  int m_sh = 0;
  int m_since = 0;
  int m_hits = 0;
  int m_st = 0;

  always #5 clk = ~clk;

  fsm_seq_detect_param #(.PAT_LEN(P), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
    .din_valid(din_valid), .din(din), .pattern(pattern),
    .overlap(overlap), .mealy_hit(mh_a), .moore_hit(mo_a),
    .hit_count(hc_a), .state_dbg(sd_a)
  );

  fsm_seq_detect_param #(.PAT_LEN(P), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
    .din_valid(din_valid), .din(din), .pattern(pattern),
    .overlap(overlap), .mealy_hit(mh_b), .moore_hit(mo_b),
    .hit_count(hc_b), .state_dbg(sd_b)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_mealy();
    bit acc;
    int w;
    acc = en & din_valid & ~clr;
    w = ((m_sh << 1) | int'(din)) & ((1 << P) - 1);
    return acc && (m_since >= P - 1) &&
           (w == int'(pattern));
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit h;
    if (!reset_n) begin
      m_sh = 0; m_since = 0; m_hits = 0; m_st = 0;
    end else begin
      h = exp_mealy();
      if (clr) begin
        m_sh = 0; m_since = 0; m_hits = 0;
        m_st = en ? 1 : 0;
      end else if (!en) begin
        m_st = 0;
      end else begin
        if (en && din_valid) begin
          m_sh = ((m_sh << 1) | int'(din)) & 'hFFFF;
          if (h) begin
            m_hits++;
            m_since = overlap ? P - 1 : 0;
          end else begin
            m_since++;
          end
        end
        if (h) m_st = 3;
        else if (m_since >= P - 1) m_st = 2;
        else m_st = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_mealy", mh_a, 0);
      chk("rst_moore", mo_a, 0);
      chk("rst_state", sd_a, 0);
      chk("rst_cnt", hc_a, 0);
    end else begin
      chk("mealy_a", mh_a, exp_mealy());
      chk("mealy_b", mh_b, exp_mealy());
      chk("moore_a", mo_a, m_st == 3);
      chk("moore_b", mo_b, m_st == 3);
      chk("state_a", sd_a, m_st);
      chk("state_b", sd_b, m_st);
      chk("cnt_a", hc_a, sat(m_hits, 255));
      chk("cnt_b", hc_b, sat(m_hits, 3));
    end
  end

  // drive one cycle; optional literal expectations at negedge
  task automatic step(bit e, bit v, bit d, bit c,
                      int em = -1, int emo = -1,
                      int est = -1);
    @(posedge clk);
    #1;
    en = e; din_valid = v; din = d; clr = c;
    @(negedge clk);
    if (em >= 0) chk("lit_mealy", mh_a, em);
    if (emo >= 0) chk("lit_moore", mo_a, emo);
    if (est >= 0) chk("lit_state", sd_a, est);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // 1: reset mid-stream
    pattern = 4'b1011; overlap = 1'b1;
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("lit_rst_state", sd_a, 0);
    chk("lit_rst_mealy", mh_a, 0);
    chk("lit_rst_moore", mo_a, 0);
    chk("lit_rst_cnt", hc_a, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);

    // 2: overlap, 1011 over 1,0,1,1,0,1,1
    step(1, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("lit_ovl_cnt", hc_a, 2);
    step(1, 0, 0, 0, 0, 0, 2);

    // 3: non-overlap
    overlap = 1'b0;
    step(1, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("lit_novl_cnt", hc_a, 1);

    // 4: back-to-back on 1111
    pattern = 4'b1111; overlap = 1'b1;
    step(1, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 1);
    step(1, 1, 1, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 2);
    chk("lit_b2b_cnt", hc_a, 3);

    // 5: bubbles and enable gap
    pattern = 4'b1011;
    step(1, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, -1, 0);
    step(1, 1, 1, 0, 0, -1, 0);
    step(1, 0, 0, 0, 0, -1, 2);
    step(1, 1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1);

    // 6: saturation then clr during a hit
    pattern = 4'b1111;
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      step(1, 1, 1, 0, (i >= 3) ? 1 : 0);
    step(1, 0, 0, 0);
    chk("lit_sat_cnt_b", hc_b, 3);
    chk("lit_sat_cnt_a", hc_a, 5);
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("lit_clr_cnt_a", hc_a, 0);
    chk("lit_clr_cnt_b", hc_b, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      if ($urandom_range(0, 19) == 0)
        overlap = 1'($urandom);
      if ($urandom_range(0, 99) == 0)
        pattern = 4'($urandom);
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 3) != 0,
           1'($urandom),
           $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_seq_detect_param.md
Name: fsm_seq_detect_param

Overview:
Parametrised serial pattern detector built as a multi-segment FSM: state register, next-state logic and output logic are separate. Compares a serial bit stream against a run-time-programmable PAT_LEN-bit pattern and reports matches two ways:
- a combinational Mealy strobe in the same cycle as the completing bit;
- a registered Moore strobe one cycle later.
Adds overlap/non-overlap mode, enable gating, synchronous clear and a saturating hit counter. Sits between a serial input stage and the status/7-seg display logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, hit_count width in bits; legal range 1..16.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
en  in  1  detector enable; 0 freezes the window and count and forces ST_IDLE.
clr  in  1  synchronous clear of window, fill and hit_count.
din_valid  in  1  din carries a bit this cycle.
din  in  1  serial data bit.
pattern  in  PAT_LEN  target pattern; MSB is the oldest bit.
overlap  in  1  1 = overlapping matches allowed; 0 = window restarts after a hit.
mealy_hit  out  1  combinational strobe: the current accepted bit completes a match.
moore_hit  out  1  registered strobe: high exactly while state is ST_HIT.
hit_count  out  CNT_W  number of matches, saturating.
state_dbg  out  2  current state encoding.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values (reset_n=0): state ST_IDLE, window 0, fill 0, hit_count 0, moore_hit 0, mealy_hit 0. Reset may be asserted at any time; it aborts any partial match.
- accept = en & din_valid & ~clr.
- Window shift on accept: win <= {win[PAT_LEN-2:0], din}. The newest bit is the LSB.
- fill counts accepted bits since the last restart and saturates at PAT_LEN-1.
- mealy_hit = accept & (fill == PAT_LEN-1) & ({win[PAT_LEN-2:0], din} == pattern). Purely combinational, zero latency.
- pattern is sampled on every accepted cycle. A change takes effect immediately, and the bits already in the window are kept.
- States (2-bit): ST_IDLE=00, ST_FILL=01, ST_ARMED=10, ST_HIT=11.
- Next-state priority, highest first:
  1. clr=1 gives ST_IDLE if en=0, else ST_FILL; window, fill and hit_count are set to 0.
  2. en=0 gives ST_IDLE; window and fill are held.
  3. mealy_hit gives ST_HIT.
  4. fill_next == PAT_LEN-1 gives ST_ARMED.
  5. Otherwise ST_FILL.
- When en returns to 1, the next state follows the same rules using the retained fill value.
- On a hit:
  - overlap=1: fill stays PAT_LEN-1, so the next accepted bit can complete another match.
  - overlap=0: fill <= 0; at least PAT_LEN new bits are needed before the next match.
- ST_HIT lasts one cycle unless the bit accepted during ST_HIT is itself a hit (possible only with overlap=1). Back-to-back hits keep moore_hit high continuously.
- moore_hit = (state == ST_HIT), so it lags the matching mealy_hit by exactly 1 cycle.
- hit_count increments by 1 on each mealy_hit and saturates at 2^CNT_W-1 (no wrap). clr has priority over the increment in the same cycle.
- A cycle with din_valid=0 while en=1 changes nothing except the state: ST_HIT exits to ST_ARMED or ST_FILL according to fill.
- overlap is sampled in the hit cycle only.

Decomposition:
- Shared package fsm_pkg:
  - state localparams ST_IDLE, ST_FILL, ST_ARMED, ST_HIT;
  - state width constant ST_W=2.
- One sub-module, sat_counter (parameter W; ports clk, reset_n, clr, inc, q), provides hit_count.
- Everything else (window, fill, FSM) stays in fsm_seq_detect_param.

Test Plan:
1. Reset: reset_n=0 asserted mid-stream after 3 matching bits -> all outputs 0 and state 00 immediately; after release, 3 further bits produce no hit.
2. Overlap: PAT_LEN=4, pattern=1011, overlap=1, stream 1,0,1,1,0,1,1 (one bit per cycle) -> mealy_hit on bits 4 and 7; moore_hit on the cycle after each; hit_count=2.
3. Non-overlap: same stream with overlap=0 -> single hit on bit 4 only; hit_count=1; state 01 after the hit.
4. Back-to-back: pattern=1111, overlap=1, six 1s -> hits on bits 4, 5, 6; moore_hit high for 3 consecutive cycles.
5. Gaps and enable: pattern=1011 with din_valid=0 bubbles between bits, plus en=0 for 2 cycles after bit 2 -> state 00 during en=0; hit still reported on the 4th accepted bit.
6. Saturation and clear: CNT_W=2, 5 hits -> hit_count holds 3; clr pulsed together with a hit -> hit_count=0, state 01, window cleared.
